mem_rmw_aligner: RTL and testbench

- Parametrised load/store alignment unit between the core's data-memory port and a synchronous word-wide RAM that has no byte enables.
- Handles byte/halfword/word (and doubleword when DATA_WIDTH=64) accesses, with sign/zero extension on loads and read-modify-write on sub-word stores.
- Handles misaligned accesses that cross a word boundary by splitting them into two word transactions.
- Sequenced by an FSM with a valid/ready request handshake and a valid/ready response handshake.

---
 rtl/mem_rmw_aligner.sv | 183 ++++++++++++++++++
 tb/tb_mem_rmw_aligner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rmw_aligner.sv
// rtl/mem_rmw_aligner.sv - load/store alignment and read-modify-write unit for a RAM without byte enables
//
// Sits between the core data port and a word-wide synchronous RAM. Sub-word
// stores are done as read-modify-write. Accesses that straddle a word
// boundary are split into two word transactions (or flagged when
// MISALIGNED_EN=0).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_*              request channel (valid/ready), LSB-aligned store data
//   resp_*             response channel (valid/ready), load data and error flag
//   mem_*              word-addressed RAM port; read data arrives the cycle after mem_re
module mem_rmw_aligner #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MISALIGNED_EN = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            req_valid,
    output logic                                            req_ready,
    input  logic                                            req_we,
    input  logic [ADDR_WIDTH-1:0]                           req_addr,
    input  logic [1:0]                                      req_size,
    input  logic                                            req_signed,
    input  logic [DATA_WIDTH-1:0]                           req_wdata,
    output logic                                            resp_valid,
    input  logic                                            resp_ready,
    output logic [DATA_WIDTH-1:0]                           resp_rdata,
    output logic                                            resp_err,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]      mem_addr,
    output logic                                            mem_re,
    output logic                                            mem_we,
    output logic [DATA_WIDTH-1:0]                           mem_wdata,
    input  logic [DATA_WIDTH-1:0]                           mem_rdata
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int MAW  = ADDR_WIDTH - OFFW;

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_WAIT, S_WAITB, S_WRA, S_WRB, S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic                  r_signed;
    logic                  r_split;
    logic                  r_err;
    logic [1:0]            r_size;
    logic [OFFW-1:0]       r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_buf_a;
    logic [DATA_WIDTH-1:0] r_buf_b;
    logic [MAW-1:0]        r_word_a;
    logic [MAW-1:0]        r_word_b;

    // Request decode, evaluated on the raw request so it can be latched on accept.
    logic                  w_accept;
    logic [3:0]            w_nbytes_in;
    logic [OFFW-1:0]       w_off_in;
    logic [MAW-1:0]        w_word_a_in;
    logic                  w_split_in;
    logic                  w_err_in;
    logic                  w_full_in;

    always_comb begin
        w_accept    = req_valid && (r_state == S_IDLE);
        w_nbytes_in = 4'd1 << req_size;
        w_off_in    = req_addr[OFFW-1:0];
        w_word_a_in = req_addr[ADDR_WIDTH-1:OFFW];
        w_split_in  = (int'(w_off_in) + int'(w_nbytes_in)) > NB;
        w_err_in    = (int'(w_nbytes_in) > NB) || (w_split_in && (MISALIGNED_EN == 0));
        // A store covering the whole word needs no read-back.
        w_full_in   = req_we && (int'(w_nbytes_in) == NB) && !w_split_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_split  <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= '0;
            r_off    <= '0;
            r_wdata  <= '0;
            r_buf_a  <= '0;
            r_buf_b  <= '0;
            r_word_a <= '0;
            r_word_b <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we;
                r_signed <= req_signed;
                r_split  <= w_split_in;
                r_err    <= w_err_in;
                r_size   <= req_size;
                r_off    <= w_off_in;
                r_wdata  <= req_wdata;
                r_word_a <= w_word_a_in;
                r_word_b <= w_word_a_in + {{(MAW-1){1'b0}}, 1'b1};
            end
            // Read data trails mem_re by one cycle: RDB and WAIT see word A, WAITB sees word B.
            case (r_state)
                S_RDB, S_WAIT: r_buf_a <= mem_rdata;
                S_WAITB:       r_buf_b <= mem_rdata;
                default:       ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (w_accept) begin
                    if (w_err_in)       w_next = S_RESP;
                    else if (w_full_in) w_next = S_WRA;
                    else                w_next = S_RDA;
                end
            S_RDA:   w_next = r_split ? S_RDB : S_WAIT;
            S_RDB:   w_next = S_WAITB;
            S_WAIT,
            S_WAITB: w_next = r_we ? S_WRA : S_RESP;
            S_WRA:   w_next = r_split ? S_WRB : S_RESP;
            S_WRB:   w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Load extraction from the {B,A} pair and lane merge for stores.
    logic [2*DATA_WIDTH-1:0] w_pair;
    logic [2*DATA_WIDTH-1:0] w_wpair;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [DATA_WIDTH-1:0]   w_merge_a;
    logic [DATA_WIDTH-1:0]   w_merge_b;
    logic                    w_sign;

    always_comb begin
        int nb;
        int off;
        nb        = 1 << r_size;
        off       = int'(r_off);
        w_pair    = {r_buf_b, r_buf_a} >> (8 * r_off);
        w_wpair   = {{DATA_WIDTH{1'b0}}, r_wdata} << (8 * r_off);
        w_sign    = 1'b0;
        w_load    = '0;
        w_merge_a = r_buf_a;
        w_merge_b = r_buf_b;
        for (int b = 0; b < NB; b++) begin
            if (b == nb - 1) w_sign = r_signed & w_pair[8*b+7];
        end
        for (int b = 0; b < NB; b++) begin
            w_load[8*b +: 8] = (b < nb) ? w_pair[8*b +: 8] : {8{w_sign}};
            if ((b >= off) && (b < off + nb))
                w_merge_a[8*b +: 8] = w_wpair[8*b +: 8];
            if (NB + b < off + nb)
                w_merge_b[8*b +: 8] = w_wpair[DATA_WIDTH + 8*b +: 8];
        end
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        mem_re     = (r_state == S_RDA) || (r_state == S_RDB);
        mem_we     = (r_state == S_WRA) || (r_state == S_WRB);
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = (r_state == S_RESP);
        resp_err   = (r_state == S_RESP) && r_err;
        resp_rdata = '0;
        if ((r_state == S_RDA) || (r_state == S_WRA)) mem_addr = r_word_a;
        if ((r_state == S_RDB) || (r_state == S_WRB)) mem_addr = r_word_b;
        if (r_state == S_WRA) mem_wdata = w_merge_a;
        if (r_state == S_WRB) mem_wdata = w_merge_b;
        if ((r_state == S_RESP) && !r_we && !r_err) resp_rdata = w_load;
    end

endmodule

// File: tb/tb_mem_rmw_aligner.sv
// tb/tb_mem_rmw_aligner.sv - self-checking scoreboard bench for mem_rmw_aligner
module tb_mem_rmw_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va, vb, req_we, req_signed, resp_ready, init_mem;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        rr_a, rv_a, re_a, we_a, err_a;
    logic        rr_b, rv_b, re_b, we_b, err_b;
    logic [31:0] rdat_a, wd_a, mrd_a, rdat_b, wd_b, mrd_b;
    logic [29:0] ma_a, ma_b;
    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];

    int cyc = 0, cnt_re = 0, cnt_we = 0;
    int n_chk = 0, n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        bit          err;
        int          lat;
        int          nre;
        int          nwe;
        int          t_acc;
        int          bre;
        int          bwe;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_rmw_aligner #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGNED_EN(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(va), .req_ready(rr_a), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(rv_a), .resp_ready(resp_ready),
        .resp_rdata(rdat_a), .resp_err(err_a), .mem_addr(ma_a), .mem_re(re_a),
        .mem_we(we_a), .mem_wdata(wd_a), .mem_rdata(mrd_a)
    );

    mem_rmw_aligner #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGNED_EN(0)) u_dut_nm (
        .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rr_b), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(rv_b), .resp_ready(resp_ready),
        .resp_rdata(rdat_b), .resp_err(err_b), .mem_addr(ma_b), .mem_re(re_b),
        .mem_we(we_b), .mem_wdata(wd_b), .mem_rdata(mrd_b)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
            mem_a[0] <= 32'h8899AABB;
            mem_a[1] <= 32'hCCDDEEFF;
            mem_b[0] <= 32'h8899AABB;
            mem_b[1] <= 32'hCCDDEEFF;
        end else begin
            if (we_a) mem_a[ma_a[3:0]] <= wd_a;
            if (re_a) mrd_a <= mem_a[ma_a[3:0]];
            if (we_b) mem_b[ma_b[3:0]] <= wd_b;
            if (re_b) mrd_b <= mem_b[ma_b[3:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cnt_re <= cnt_re + int'(re_a) + int'(re_b);
        cnt_we <= cnt_we + int'(we_a) + int'(we_b);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_resp();
        exp_t e;
        bit   got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            #1;
            if (rv_a || rv_b) got = 1'b1;
        end
        if (sb.size() == 0) begin
            check_val("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            if (!got) begin
                check_val({e.tag, "_timeout"}, 64'd0, 64'd1);
            end else begin
                check_val({e.tag, "_rdata"}, rv_b ? rdat_b : rdat_a, e.rd);
                check_val({e.tag, "_err"}, rv_b ? err_b : err_a, e.err);
                check_val({e.tag, "_lat"}, cyc - e.t_acc + 1, e.lat);
                check_val({e.tag, "_nre"}, cnt_re - e.bre, e.nre);
                check_val({e.tag, "_nwe"}, cnt_we - e.bwe, e.nwe);
            end
        end
    endtask

    task automatic issue(input string tag, input bit sel, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit sgn, input logic [31:0] wdata,
                         input logic [31:0] rd, input bit err, input int lat, input int nre,
                         input int nwe);
        check_val({tag, "_rdy"}, sel ? rr_b : rr_a, 64'd1);
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        if (sel) vb = 1'b1;
        else     va = 1'b1;
        sb.push_back('{tag, rd, err, lat, nre, nwe, cyc + 1, cnt_re, cnt_we});
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        wait_resp();
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load_mem();
        init_mem = 1'b1;
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;
        int n_we;
        va = 0; vb = 0; req_we = 0; req_signed = 0; resp_ready = 1;
        req_addr = 0; req_wdata = 0; req_size = 0; init_mem = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        init_mem = 1'b0;
        rst = 1'b0;
        #1;
        check_val("rst_req_ready", rr_a, 64'd1);
        check_val("rst_flags", {rv_a, re_a, we_a, err_a}, 64'd0);
        check_val("rst_mem_addr", ma_a, 64'd0);
        check_val("rst_mem_wdata", wd_a, 64'd0);
        check_val("rst_resp_rdata", rdat_a, 64'd0);

        issue("ldb_s", 0, 0, 32'h2, 2'd0, 1, 32'h0, 32'hFFFFFF99, 0, 3, 1, 0); finish_resp();
        issue("ldb_u", 0, 0, 32'h2, 2'd0, 0, 32'h0, 32'h00000099, 0, 3, 1, 0); finish_resp();
        issue("ldh_s", 0, 0, 32'h2, 2'd1, 1, 32'h0, 32'hFFFF8899, 0, 3, 1, 0); finish_resp();
        issue("ldw_split", 0, 0, 32'h3, 2'd2, 0, 32'h0, 32'hDDEEFF88, 0, 4, 2, 0); finish_resp();
        issue("ldd_err", 0, 0, 32'h0, 2'd3, 0, 32'h0, 32'h0, 1, 1, 0, 0); finish_resp();
        issue("nm_ldw_err", 1, 0, 32'h2, 2'd2, 0, 32'h0, 32'h0, 1, 1, 0, 0); finish_resp();
        issue("nm_stw", 1, 1, 32'h4, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1); finish_resp();
        check_val("nm_stw_w1", mem_b[1], 64'hDEADBEEF);
        check_val("nm_stw_w0", mem_b[0], 64'h8899AABB);
        issue("sth", 0, 1, 32'h1, 2'd1, 1, 32'hA5A51234, 32'h0, 0, 4, 1, 1); finish_resp();
        check_val("sth_w0", mem_a[0], 64'h881234BB);
        check_val("sth_w1", mem_a[1], 64'hCCDDEEFF);

        load_mem();
        issue("stw_split", 0, 1, 32'h3, 2'd2, 0, 32'h11223344, 32'h0, 0, 6, 2, 2); finish_resp();
        check_val("stw_split_w0", mem_a[0], 64'h4499AABB);
        check_val("stw_split_w1", mem_a[1], 64'hCC112233);

        // Response back-pressure with a request already waiting.
        load_mem();
        resp_ready = 1'b0;
        issue("stall_ld", 0, 0, 32'h0, 2'd0, 0, 32'h0, 32'h000000BB, 0, 3, 1, 0);
        req_we = 0; req_addr = 32'h4; req_size = 2'd2; req_signed = 0; va = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("stall_valid", rv_a, 64'd1);
            check_val("stall_rdata", rdat_a, 64'h000000BB);
            check_val("stall_err", err_a, 64'd0);
            check_val("stall_req_ready", rr_a, 64'd0);
            @(negedge clk);
            #1;
        end
        resp_ready = 1'b1;
        sb.push_back('{"pend_ld", 32'hCCDDEEFF, 1'b0, 3, 1, 0, cyc + 2, cnt_re, cnt_we});
        @(negedge clk);
        #1;
        check_val("pend_idle_rdy", rr_a, 64'd1);
        check_val("pend_resp_low", rv_a, 64'd0);
        @(posedge clk);
        #1;
        va = 1'b0;
        wait_resp();
        finish_resp();

        // Asynchronous reset in the middle of a split store.
        load_mem();
        req_we = 1; req_addr = 32'h3; req_size = 2'd2; req_signed = 0; req_wdata = 32'h11223344;
        va = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (we_a) hit = 1'b1;
        end
        check_val("rst_reach_wra", hit, 64'd1);
        n_we = cnt_we;
        rst = 1'b1;
        #1;
        check_val("rst_async_we", we_a, 64'd0);
        check_val("rst_async_re", re_a, 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("rst_rel_req_ready", rr_a, 64'd1);
        check_val("rst_rel_resp_valid", rv_a, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_no_wrb", cnt_we - n_we, 64'd0);
        check_val("rst_w1_kept", mem_a[1], 64'hCCDDEEFF);
        issue("post_rst_ld", 0, 0, 32'h4, 2'd2, 1, 32'h0, 32'hCCDDEEFF, 0, 3, 1, 0); finish_resp();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
